// File: rtl/arm_pkg.sv
// ARM execute-stage shared encodings.
// ALU commands, condition codes and NZCV bit positions.
package arm_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/exe_alu_stage_if.sv
// ID/EXE bundle feeding the execute stage.
// Decode side drives (master), execute side consumes (slave).
interface exe_alu_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              valid_in;
  logic [3:0]        exe_cmd;
  logic              s_bit;
  logic [3:0]        cond;
  logic              is_branch;
  logic              wb_en_in;
  logic              mem_r_in;
  logic              mem_w_in;
  logic [REG_AW-1:0] dest_in;
  logic [DATA_W-1:0] pc_in;
  logic [23:0]       imm24;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] val_rm;

  modport master (
    output valid_in, exe_cmd, s_bit, cond,
    output is_branch, wb_en_in, mem_r_in,
    output mem_w_in, dest_in, pc_in, imm24,
    output val1, val2, val_rm
  );

  modport slave (
    input valid_in, exe_cmd, s_bit, cond,
    input is_branch, wb_en_in, mem_r_in,
    input mem_w_in, dest_in, pc_in, imm24,
    input val1, val2, val_rm
  );
endinterface

// File: rtl/cond_check.sv
// ARM condition evaluator.
// Maps cond field and NZCV to a pass bit.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[N_BIT];
  assign z = nzcv_i[Z_BIT];
  assign c = nzcv_i[C_BIT];
  assign v = nzcv_i[V_BIT];

  // Decode condition field against current flags
  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      CC_EQ: pass_o = z;
      CC_NE: pass_o = !z;
      CC_CS: pass_o = c;
      CC_CC: pass_o = !c;
      CC_MI: pass_o = n;
      CC_PL: pass_o = !n;
      CC_VS: pass_o = v;
      CC_VC: pass_o = !v;
      CC_HI: pass_o = c & !z;
      CC_LS: pass_o = !c | z;
      CC_GE: pass_o = (n == v);
      CC_LT: pass_o = (n != v);
      CC_GT: pass_o = !z & (n == v);
      CC_LE: pass_o = z | (n != v);
      CC_AL: pass_o = 1'b1;
      CC_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_alu_stage.sv
// ARM execute stage: ALU, condition check, NZCV,
// EXE/MEM register and branch target generation.
module exe_alu_stage
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  exe_alu_stage_if.slave    id,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [REG_AW-1:0] dest,
  output logic              wb_en,
  output logic              mem_r,
  output logic              mem_w,
  output logic              valid_out,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_addr,
  output logic [3:0]        nzcv
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] alu_res_q;
  logic [DATA_W-1:0] st_val_q;
  logic [REG_AW-1:0] dest_q;
  logic              wb_en_q, mem_r_q, mem_w_q;
  logic              valid_q;
  logic [3:0]        nzcv_q, nzcv_d;

  logic              pass;
  logic              exec;
  logic              is_sub, is_arith, cin;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res_d;
  logic              ovf;

  cond_check u_cond (
    .cond_i (id.cond),
    .nzcv_i (nzcv_q),
    .pass_o (pass)
  );

  assign exec = id.valid_in & pass & !flush;

  // Shared adder: subtraction is val1 + ~val2 + carry-in
  always_comb begin
    is_sub   = 1'b0;
    is_arith = 1'b0;
    cin      = 1'b0;
    unique case (id.exe_cmd)
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin
        is_arith = 1'b1;
        cin      = nzcv_q[C_BIT];
      end
      CMD_SUB: begin
        is_arith = 1'b1;
        is_sub   = 1'b1;
        cin      = 1'b1;
      end
      CMD_SBC: begin
        is_arith = 1'b1;
        is_sub   = 1'b1;
        cin      = nzcv_q[C_BIT];
      end
      default: ;
    endcase
    op_b = is_sub ? ~id.val2 : id.val2;
    sum  = {1'b0, id.val1} + {1'b0, op_b}
         + {{DATA_W{1'b0}}, cin};
    ovf  = (id.val1[MSB] == op_b[MSB])
         & (sum[MSB] != id.val1[MSB]);
  end

  // Result mux and next flags (C/V kept for logic ops)
  always_comb begin
    res_d = '0;
    unique case (id.exe_cmd)
      CMD_MOV: res_d = id.val2;
      CMD_MVN: res_d = ~id.val2;
      CMD_ADD,
      CMD_ADC,
      CMD_SUB,
      CMD_SBC: res_d = sum[MSB:0];
      CMD_AND: res_d = id.val1 & id.val2;
      CMD_ORR: res_d = id.val1 | id.val2;
      CMD_EOR: res_d = id.val1 ^ id.val2;
      default: res_d = '0;
    endcase
    nzcv_d        = nzcv_q;
    nzcv_d[N_BIT] = res_d[MSB];
    nzcv_d[Z_BIT] = (res_d == '0);
    if (is_arith) begin
      nzcv_d[C_BIT] = sum[DATA_W];
      nzcv_d[V_BIT] = ovf;
    end
  end

  // EXE/MEM register and status flags; freeze holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_res_q <= '0;
      st_val_q  <= '0;
      dest_q    <= '0;
      wb_en_q   <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      valid_q   <= 1'b0;
      nzcv_q    <= 4'b0000;
    end else if (!freeze) begin
      alu_res_q <= res_d;
      st_val_q  <= id.val_rm;
      dest_q    <= id.dest_in;
      wb_en_q   <= id.wb_en_in & exec;
      mem_r_q   <= id.mem_r_in & exec;
      mem_w_q   <= id.mem_w_in & exec;
      valid_q   <= id.valid_in & !flush;
      if (exec && id.s_bit) nzcv_q <= nzcv_d;
    end
  end

  assign alu_res   = alu_res_q;
  assign st_val    = st_val_q;
  assign dest      = dest_q;
  assign wb_en     = wb_en_q;
  assign mem_r     = mem_r_q;
  assign mem_w     = mem_w_q;
  assign valid_out = valid_q;
  assign nzcv      = nzcv_q;

  assign br_taken = id.is_branch & id.valid_in & pass
                  & !flush & !freeze;
  assign br_addr  = id.pc_in
                  + ({{(DATA_W-24){id.imm24[23]}}, id.imm24} << 2);

endmodule

// File: tb/tb_exe_alu_stage.sv
// Scoreboard bench for exe_alu_stage.
// Directed vectors, expectations queued per cycle.
module tb_exe_alu_stage;
  import arm_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dst;
    logic [3:0]  ctl;
    logic [3:0]  nzcv;
  } rexp_t;

  typedef struct {
    int          cyc;
    logic        tk;
    logic [31:0] addr;
  } bexp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] alu_res, st_val, br_addr;
  logic [3:0]  dest, nzcv;
  logic        wb_en, mem_r, mem_w, valid_out, br_taken;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  rexp_t rq[$];
  bexp_t bq[$];
  rexp_t last;

  exe_alu_stage_if #(.DATA_W(32), .REG_AW(4)) ifc ();

  exe_alu_stage #(.DATA_W(32), .REG_AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .freeze    (freeze),
    .flush     (flush),
    .id        (ifc),
    .alu_res   (alu_res),
    .st_val    (st_val),
    .dest      (dest),
    .wb_en     (wb_en),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .valid_out (valid_out),
    .br_taken  (br_taken),
    .br_addr   (br_addr),
    .nzcv      (nzcv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: compare queued expectations at the falling edge
  always @(negedge clk) begin
    while (rq.size() > 0 && rq[0].cyc <= cyc) begin
      rexp_t e;
      e = rq.pop_front();
      checks++;
      if (e.cyc != cyc ||
          {alu_res, st_val, dest,
           wb_en, mem_r, mem_w, valid_out, nzcv} !==
          {e.alu, e.st, e.dst, e.ctl, e.nzcv}) begin
        errors++;
        $display("FAIL reg cyc=%0d got alu=%h st=%h dst=%h wb/mr/mw/vo=%b%b%b%b nzcv=%b want cyc=%0d alu=%h st=%h dst=%h ctl=%b nzcv=%b",
                 cyc, alu_res, st_val, dest, wb_en, mem_r,
                 mem_w, valid_out, nzcv, e.cyc, e.alu, e.st,
                 e.dst, e.ctl, e.nzcv);
      end
    end
    while (bq.size() > 0 && bq[0].cyc <= cyc) begin
      bexp_t b;
      b = bq.pop_front();
      checks++;
      if (b.cyc != cyc ||
          {br_taken, br_addr} !== {b.tk, b.addr}) begin
        errors++;
        $display("FAIL br cyc=%0d got tk=%b addr=%h want tk=%b addr=%h",
                 cyc, br_taken, br_addr, b.tk, b.addr);
      end
    end
  end

  task automatic idle();
    ifc.valid_in  = 1'b0;
    ifc.exe_cmd   = 4'b0000;
    ifc.s_bit     = 1'b0;
    ifc.cond      = CC_AL;
    ifc.is_branch = 1'b0;
    ifc.wb_en_in  = 1'b0;
    ifc.mem_r_in  = 1'b0;
    ifc.mem_w_in  = 1'b0;
    ifc.dest_in   = 4'd0;
    ifc.pc_in     = 32'd0;
    ifc.imm24     = 24'd0;
    ifc.val1      = 32'd0;
    ifc.val2      = 32'd0;
    ifc.val_rm    = 32'd0;
    freeze        = 1'b0;
    flush         = 1'b0;
  endtask

  // ctl = {wb,mr,mw}; e_ctl = {wb,mr,mw,valid}
  task automatic step(
    input logic [3:0]  cmd,
    input logic        s,
    input logic [3:0]  cnd,
    input logic        br,
    input logic [2:0]  ctl,
    input logic [3:0]  dst,
    input logic [31:0] pc,
    input logic [23:0] imm,
    input logic [31:0] v1,
    input logic [31:0] v2,
    input logic [31:0] vrm,
    input logic        vld,
    input logic        fl,
    input logic        fz,
    input logic [31:0] e_alu,
    input logic [3:0]  e_nzcv,
    input logic [3:0]  e_ctl,
    input logic        e_tk,
    input logic [31:0] e_addr
  );
    rexp_t e;
    bexp_t b;
    @(posedge clk);
    #1;
    ifc.valid_in  = vld;
    ifc.exe_cmd   = cmd;
    ifc.s_bit     = s;
    ifc.cond      = cnd;
    ifc.is_branch = br;
    ifc.wb_en_in  = ctl[2];
    ifc.mem_r_in  = ctl[1];
    ifc.mem_w_in  = ctl[0];
    ifc.dest_in   = dst;
    ifc.pc_in     = pc;
    ifc.imm24     = imm;
    ifc.val1      = v1;
    ifc.val2      = v2;
    ifc.val_rm    = vrm;
    flush         = fl;
    freeze        = fz;
    b.cyc  = cyc;
    b.tk   = e_tk;
    b.addr = e_addr;
    bq.push_back(b);
    if (fz) begin
      e = last;
    end else begin
      e.alu  = e_alu;
      e.st   = vrm;
      e.dst  = dst;
      e.ctl  = e_ctl;
      e.nzcv = e_nzcv;
      last   = e;
    end
    e.cyc = cyc + 1;
    rq.push_back(e);
  endtask

  task automatic chk_reset(input string tag);
    checks++;
    if ({alu_res, st_val, dest, wb_en, mem_r, mem_w,
         valid_out, nzcv} !== 84'd0) begin
      errors++;
      $display("FAIL %s got alu=%h st=%h dst=%h wb/mr/mw/vo=%b%b%b%b nzcv=%b want all zero",
               tag, alu_res, st_val, dest, wb_en, mem_r,
               mem_w, valid_out, nzcv);
    end
  endtask

  initial begin
    idle();
    last = '{0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0};
    #3;
    chk_reset("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD carry out to zero
    step(CMD_ADD, 1, CC_AL, 0, 3'b100, 4'd1, 0, 0,
         32'hFFFF_FFFF, 32'd1, 32'h11, 1, 0, 0,
         32'd0, 4'b0110, 4'b1001, 0, 32'd0);
    // SUB signed overflow
    step(CMD_SUB, 1, CC_AL, 0, 3'b100, 4'd2, 0, 0,
         32'h8000_0000, 32'd1, 32'h22, 1, 0, 0,
         32'h7FFF_FFFF, 4'b0011, 4'b1001, 0, 32'd0);
    // EQ fails on Z=0
    step(CMD_MOV, 0, CC_EQ, 0, 3'b100, 4'd3, 0, 0,
         32'd0, 32'h55, 32'h33, 1, 0, 0,
         32'h55, 4'b0011, 4'b0001, 0, 32'd0);
    // CMP 5,5
    step(CMD_SUB, 1, CC_AL, 0, 3'b000, 4'd0, 0, 0,
         32'd5, 32'd5, 32'd0, 1, 0, 0,
         32'd0, 4'b0110, 4'b0001, 0, 32'd0);
    // BEQ back-to-back
    step(4'b0000, 0, CC_EQ, 1, 3'b000, 4'd0, 32'h100,
         24'hFFFFFE, 32'd0, 32'd0, 32'd0, 1, 0, 0,
         32'd0, 4'b0110, 4'b0001, 1, 32'hF8);
    // ORR held by freeze (one frozen slot also flushed)
    step(CMD_ORR, 1, CC_AL, 1, 3'b100, 4'd4, 32'h200,
         24'd1, 32'hF0, 32'h0F, 32'h44, 1, 0, 1,
         32'd0, 4'd0, 4'd0, 0, 32'h204);
    step(CMD_ORR, 1, CC_AL, 1, 3'b100, 4'd4, 32'h200,
         24'd1, 32'hF0, 32'h0F, 32'h44, 1, 1, 1,
         32'd0, 4'd0, 4'd0, 0, 32'h204);
    step(CMD_ORR, 1, CC_AL, 1, 3'b100, 4'd4, 32'h200,
         24'd1, 32'hF0, 32'h0F, 32'h44, 1, 0, 1,
         32'd0, 4'd0, 4'd0, 0, 32'h204);
    step(CMD_ORR, 1, CC_AL, 1, 3'b100, 4'd4, 32'h200,
         24'd1, 32'hF0, 32'h0F, 32'h44, 1, 0, 0,
         32'hFF, 4'b0010, 4'b1001, 1, 32'h204);
    // flushed store with s_bit
    step(CMD_ADD, 1, CC_AL, 0, 3'b001, 4'd5, 0, 0,
         32'd1, 32'd1, 32'h77, 1, 1, 0,
         32'd2, 4'b0010, 4'b0000, 0, 32'd0);
    // MVN sets N, keeps C
    step(CMD_MVN, 1, CC_AL, 0, 3'b100, 4'd6, 0, 0,
         32'd0, 32'd0, 32'd0, 1, 0, 0,
         32'hFFFF_FFFF, 4'b1010, 4'b1001, 0, 32'd0);
    // GE fails (N!=V): flags and load gated
    step(CMD_AND, 1, CC_GE, 0, 3'b010, 4'd7, 0, 0,
         32'hFF, 32'h0F, 32'd0, 1, 0, 0,
         32'h0F, 4'b1010, 4'b0001, 0, 32'd0);
    // LT passes
    step(CMD_EOR, 1, CC_LT, 0, 3'b010, 4'd8, 0, 0,
         32'hFF, 32'hFF, 32'd0, 1, 0, 0,
         32'd0, 4'b0110, 4'b0101, 0, 32'd0);
    // NV never executes
    step(CMD_MOV, 1, CC_NV, 0, 3'b100, 4'd9, 0, 0,
         32'd0, 32'h8000_0000, 32'd0, 1, 0, 0,
         32'h8000_0000, 4'b0110, 4'b0001, 0, 32'd0);

    // asynchronous reset between edges
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("reset_async");
    idle();
    last = '{0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0};
    @(negedge clk);
    rst_n = 1'b1;

    // ADC after reset sees C=0
    step(CMD_ADC, 1, CC_AL, 0, 3'b100, 4'd1, 0, 0,
         32'h10, 32'h20, 32'd0, 1, 0, 0,
         32'h30, 4'b0000, 4'b1001, 0, 32'd0);
    step(CMD_ADD, 1, CC_AL, 0, 3'b100, 4'd2, 0, 0,
         32'hFFFF_FFFF, 32'd2, 32'd0, 1, 0, 0,
         32'd1, 4'b0010, 4'b1001, 0, 32'd0);
    // ADC with C=1
    step(CMD_ADC, 1, CC_AL, 0, 3'b100, 4'd3, 0, 0,
         32'd1, 32'd1, 32'd0, 1, 0, 0,
         32'd3, 4'b0000, 4'b1001, 0, 32'd0);
    // SBC with C=0 subtracts one extra
    step(CMD_SBC, 1, CC_AL, 0, 3'b100, 4'd4, 0, 0,
         32'h10, 32'd3, 32'd0, 1, 0, 0,
         32'h0C, 4'b0010, 4'b1001, 0, 32'd0);

    @(posedge clk);
    #1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rq.size() != 0 || bq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0",
               rq.size(), bq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
